alu_mul_sequencer: RTL and testbench

- Multi-cycle sequencer for 32-bit unsigned multiply, low word only (MUL, result mod 2^32), using shift-and-add.
- Sits in front of the shared EX-stage ALU.
- When idle, passes the pipeline's ALU operands and opcode straight through to the ALU.
- When a multiply is running, it owns the ALU, drives ADD every cycle and stalls the pipeline until the product is ready.

---
 rtl/alu_mul_sequencer_if.sv | 37 +++
 rtl/alu_mul_sequencer.sv | 116 +++++++++++
 tb/tb_alu_mul_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_if.sv
// Handshake/bus bundle between pipeline, shared ALU and the multiply sequencer.
// Signals: start/mul_a/mul_b request, pipe_* pass-through, alu_* ALU side, busy/done/result.
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] pipe_a;
  logic [WIDTH-1:0] pipe_b;
  logic [2:0]       pipe_signal;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_signal;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  // Pipeline/ALU side of the bundle.
  modport master (
    output start, mul_a, mul_b,
    output pipe_a, pipe_b, pipe_signal,
    output alu_out,
    input  alu_a, alu_b, alu_signal,
    input  busy, done, result
  );

  // Sequencer side of the bundle.
  modport slave (
    input  start, mul_a, mul_b,
    input  pipe_a, pipe_b, pipe_signal,
    input  alu_out,
    output alu_a, alu_b, alu_signal,
    output busy, done, result
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add MUL (low word) sequencer that borrows the shared EX ALU adder.
// Ports: clk, rst (async high), bus (slave modport). Option macro: MUL_EARLY_EXIT_EN.
module alu_mul_sequencer #(
  parameter int         WIDTH    = 32,
  parameter logic [2:0] ADD_CODE = 3'b010
) (
  input  logic              clk,
  input  logic              rst,
  alu_mul_sequencer_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] acc_nxt;
  logic             last;
  logic             idle;

  assign idle = (state_q == IDLE);

  // ALU is ours outside IDLE; it only ever adds acc + mcand.
  assign bus.alu_a      = idle ? bus.pipe_a      : acc_q;
  assign bus.alu_b      = idle ? bus.pipe_b      : mcand_q;
  assign bus.alu_signal = idle ? bus.pipe_signal : ADD_CODE;

  assign bus.busy   = !idle;
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;

  // Accumulate only when the current multiplier bit is set.
  assign acc_nxt = mplier_q[0] ? bus.alu_out : acc_q;

  always_comb begin
    last = (cnt_q == CW'(WIDTH - 1));
`ifdef MUL_EARLY_EXIT_EN
    // No higher multiplier bits left to add.
    if ((mplier_q >> 1) == '0) begin
      last = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d    = '0;
          mcand_d  = bus.mul_a;
          mplier_d = bus.mul_b;
          cnt_d    = '0;
`ifdef MUL_EARLY_EXIT_EN
          if (bus.mul_b == '0) begin
            state_d  = DONE;
            result_d = '0;
          end else begin
            state_d = RUN;
          end
`else
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last) begin
          state_d  = DONE;
          result_d = acc_nxt;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a small behavioural ALU.
// Checks reset, pass-through, latency, wrap, ignored start, mid-run reset, held start.
module tb_alu_mul_sequencer;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;

`ifdef MUL_EARLY_EXIT_EN
  localparam int LAT_3X5 = 4;
  localparam int LAT_7X5 = 4;
  localparam int LAT_B0  = 1;
  localparam int LAT_B2  = 3;
  localparam int LAT_407 = 12;
`else
  localparam int LAT_3X5 = 33;
  localparam int LAT_7X5 = 33;
  localparam int LAT_B0  = 33;
  localparam int LAT_B2  = 33;
  localparam int LAT_407 = 33;
`endif
  localparam int LAT_FULL = 33;

  always #5 clk = ~clk;

  alu_mul_sequencer_if #(.WIDTH(32)) bus ();

  alu_mul_sequencer #(
    .WIDTH(32),
    .ADD_CODE(3'b010)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always_comb begin
    case (bus.alu_signal)
      3'b000:  bus.alu_out = bus.alu_a & bus.alu_b;
      3'b001:  bus.alu_out = bus.alu_a | bus.alu_b;
      3'b010:  bus.alu_out = bus.alu_a + bus.alu_b;
      3'b110:  bus.alu_out = bus.alu_a - bus.alu_b;
      default: bus.alu_out = '0;
    endcase
  end

  // Stimulus only: issue a multiply and wait for done (bounded).
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output int lat, output bit to);
    bus.start = 1'b1;
    bus.mul_a = a;
    bus.mul_b = b;
    lat = 0;
    to = 1'b0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!hold) bus.start = 1'b0;
    end while (!bus.done && lat < 100);
    if (!bus.done) to = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b want=0", bus.busy);
    end
    total++;
    if (bus.done !== 1'b0) begin
      bad++; $display("FAIL reset_done got=%b want=0", bus.done);
    end
    total++;
    if (bus.result !== 32'd0) begin
      bad++; $display("FAIL reset_result got=%h want=0", bus.result);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_passthrough();
    bus.pipe_a = 32'd4;
    bus.pipe_b = 32'd60;
    bus.pipe_signal = 3'b000;
    #1;
    total++;
    if (bus.alu_a !== 32'd4) begin
      bad++; $display("FAIL pass_a got=%h want=4", bus.alu_a);
    end
    total++;
    if (bus.alu_b !== 32'd60) begin
      bad++; $display("FAIL pass_b got=%h want=3c", bus.alu_b);
    end
    total++;
    if (bus.alu_signal !== 3'b000) begin
      bad++; $display("FAIL pass_sig got=%b want=000", bus.alu_signal);
    end
    bus.pipe_a = 32'd7;
    bus.pipe_signal = 3'b110;
    #1;
    total++;
    if (bus.alu_a !== 32'd7 || bus.alu_signal !== 3'b110) begin
      bad++;
      $display("FAIL pass_chg got a=%h sig=%b want a=7 sig=110",
               bus.alu_a, bus.alu_signal);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int lat;
    bus.pipe_a = 32'd99;
    bus.pipe_b = 32'd77;
    bus.pipe_signal = 3'b110;
    bus.start = 1'b1;
    bus.mul_a = 32'd3;
    bus.mul_b = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 1;
    total++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy got busy=%b done=%b want 1/0",
               bus.busy, bus.done);
    end
    total++;
    if (bus.alu_signal !== 3'b010 || bus.alu_a !== 32'd0 ||
        bus.alu_b !== 32'd3) begin
      bad++;
      $display("FAIL run_mux0 got sig=%b a=%h b=%h want 010/0/3",
               bus.alu_signal, bus.alu_a, bus.alu_b);
    end
    @(posedge clk);
    #1;
    lat++;
    total++;
    if (bus.alu_a !== 32'd3 || bus.alu_b !== 32'd6) begin
      bad++;
      $display("FAIL run_mux1 got a=%h b=%h want 3/6",
               bus.alu_a, bus.alu_b);
    end
    while (!bus.done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat !== LAT_3X5) begin
      bad++; $display("FAIL basic_lat got=%0d want=%0d", lat, LAT_3X5);
    end
    total++;
    if (bus.result !== 32'd15) begin
      bad++; $display("FAIL basic_res got=%h want=f", bus.result);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_pulse got done=%b busy=%b want 0/0",
               bus.done, bus.busy);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.result !== 32'd15) begin
      bad++; $display("FAIL basic_hold got=%h want=f", bus.result);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] vr [5];
    int vl [5];
    int lat;
    bit to;
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF; vr[0] = 32'h1;
    vl[0] = LAT_FULL;
    va[1] = 32'h8000_0000; vb[1] = 32'd2; vr[1] = 32'h0;
    vl[1] = LAT_B2;
    va[2] = 32'd7; vb[2] = 32'd5; vr[2] = 32'd35;
    vl[2] = LAT_7X5;
    va[3] = 32'd9; vb[3] = 32'd0; vr[3] = 32'd0;
    vl[3] = LAT_B0;
    va[4] = 32'd1; vb[4] = 32'h8000_0000; vr[4] = 32'h8000_0000;
    vl[4] = LAT_FULL;
    for (int i = 0; i < 5; i++) begin
      do_mul(va[i], vb[i], 1'b0, lat, to);
      total++;
      if (to) begin
        bad++; $display("FAIL vec%0d_timeout got=none want=done", i);
      end
      total++;
      if (bus.result !== vr[i]) begin
        bad++;
        $display("FAIL vec%0d_res got=%h want=%h", i, bus.result, vr[i]);
      end
      total++;
      if (lat !== vl[i]) begin
        bad++;
        $display("FAIL vec%0d_lat got=%0d want=%0d", i, lat, vl[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int dones;
    int dlat;
    bus.start = 1'b1;
    bus.mul_a = 32'd6;
    bus.mul_b = 32'h407;
    dones = 0;
    dlat = 0;
    for (lat = 1; lat <= 45; lat++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        if (dlat == 0) dlat = lat;
      end
      if (lat == 10) begin
        bus.start = 1'b1;
        bus.mul_a = 32'd100;
        bus.mul_b = 32'd200;
      end
    end
    total++;
    if (dones !== 1) begin
      bad++; $display("FAIL ign_dones got=%0d want=1", dones);
    end
    total++;
    if (dlat !== LAT_407) begin
      bad++; $display("FAIL ign_lat got=%0d want=%0d", dlat, LAT_407);
    end
    total++;
    if (bus.result !== 32'd6186 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL ign_res got res=%h busy=%b want 182a/0",
               bus.result, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit to;
    bus.pipe_signal = 3'b110;
    bus.start = 1'b1;
    bus.mul_a = 32'd3;
    bus.mul_b = 32'h0001_0009;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    total++;
    if (bus.busy !== 1'b1) begin
      bad++; $display("FAIL rmid_pre got busy=%b want=1", bus.busy);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL rmid_ctl got busy=%b done=%b want 0/0",
               bus.busy, bus.done);
    end
    total++;
    if (bus.result !== 32'd0) begin
      bad++; $display("FAIL rmid_res got=%h want=0", bus.result);
    end
    total++;
    if (bus.alu_signal !== 3'b110) begin
      bad++; $display("FAIL rmid_mux got=%b want=110", bus.alu_signal);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_mul(32'd12, 32'd13, 1'b0, lat, to);
    total++;
    if (to || bus.result !== 32'd156) begin
      bad++;
      $display("FAIL rmid_after got=%h to=%b want=9c", bus.result, to);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_start_held();
    int lat;
    bit to;
    do_mul(32'd2, 32'd3, 1'b1, lat, to);
    total++;
    if (to || bus.result !== 32'd6) begin
      bad++; $display("FAIL held1 got=%h to=%b want=6", bus.result, to);
    end
    bus.mul_a = 32'd5;
    bus.mul_b = 32'd5;
    @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL held_idle got busy=%b done=%b want 0/0",
               bus.busy, bus.done);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++; $display("FAIL held_acc got busy=%b want=1", bus.busy);
    end
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (!bus.done || bus.result !== 32'd25) begin
      bad++;
      $display("FAIL held2 got=%h done=%b want=19", bus.result, bus.done);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.mul_a = '0;
    bus.mul_b = '0;
    bus.pipe_a = '0;
    bus.pipe_b = '0;
    bus.pipe_signal = 3'b000;
    test_reset();
    test_passthrough();
    test_basic();
    test_vectors();
    test_ignore_start();
    test_reset_mid();
    test_start_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
